// File: rtl/stream_muxn_if.sv
// Handshake bundle for stream_muxn: N valid/ready input channels merged onto one output stream.
// The slave modport is the mux's view; master is the producer/consumer side.
interface stream_muxn_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 4
);
  localparam int unsigned SELW = $clog2(N);

  logic [SELW-1:0]    sel;
  logic [N-1:0]       in_valid;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_src;
  logic               out_ready;

  modport master (
    output sel, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_src
  );

  modport slave (
    input  sel, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_src
  );
endinterface

// File: rtl/stream_muxn.sv
// N-to-1 stream mux with registered output and a one-entry skid buffer.
// Channel choice comes from sel (MODE 0) or a round-robin pointer over valid inputs (MODE 1).
module stream_muxn #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 4,
  parameter int unsigned MODE  = 0
) (
  input logic          clk,
  input logic          reset,
  stream_muxn_if.slave bus
);
  localparam int unsigned SELW = $clog2(N);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] m_data_q, m_data_d, s_data_q, s_data_d;
  logic [SELW-1:0]  m_src_q, m_src_d, s_src_q, s_src_d;
  logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;

  logic             grant_valid;
  logic [SELW-1:0]  grant_idx;
  logic [SELW:0]    cand;
  logic [N-1:0]     in_ready;
  logic             in_xfer, out_xfer;
  logic [WIDTH-1:0] in_word;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    if (MODE == 0) begin
      // Extra MSB keeps the compare meaningful when N is a power of two.
      if ({1'b0, bus.sel} < (SELW+1)'(N)) begin
        grant_valid = 1'b1;
        grant_idx   = bus.sel;
      end
    end else begin
      for (int unsigned k = 0; k < N; k++) begin
        cand = {1'b0, rr_ptr_q} + (SELW+1)'(k);
        if (cand >= (SELW+1)'(N)) cand = cand - (SELW+1)'(N);
        if (!grant_valid && bus.in_valid[cand[SELW-1:0]]) begin
          grant_valid = 1'b1;
          grant_idx   = cand[SELW-1:0];
        end
      end
    end
  end

  // Ready never looks at out_ready: only skid occupancy and the grant matter.
  always_comb begin
    in_ready = '0;
    if (!reset && grant_valid && (state_q != StFull)) in_ready[grant_idx] = 1'b1;
  end

  assign in_xfer  = |(bus.in_valid & in_ready);
  assign out_xfer = (state_q != StEmpty) && bus.out_ready;
  assign in_word  = bus.in_data[32'(grant_idx) * WIDTH +: WIDTH];

  always_comb begin
    state_d  = state_q;
    m_data_d = m_data_q;
    m_src_d  = m_src_q;
    s_data_d = s_data_q;
    s_src_d  = s_src_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      StEmpty: begin
        if (in_xfer) begin
          m_data_d = in_word;
          m_src_d  = grant_idx;
          state_d  = StOne;
        end
      end
      StOne: begin
        if (in_xfer && out_xfer) begin
          m_data_d = in_word;
          m_src_d  = grant_idx;
        end else if (in_xfer) begin
          s_data_d = in_word;
          s_src_d  = grant_idx;
          state_d  = StFull;
        end else if (out_xfer) begin
          state_d  = StEmpty;
        end
      end
      StFull: begin
        if (out_xfer) begin
          m_data_d = s_data_q;
          m_src_d  = s_src_q;
          state_d  = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
    if ((MODE != 0) && in_xfer) begin
      rr_ptr_d = (grant_idx == SELW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StEmpty;
      m_data_q <= '0;
      m_src_q  <= '0;
      s_data_q <= '0;
      s_src_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      m_data_q <= m_data_d;
      m_src_q  <= m_src_d;
      s_data_q <= s_data_d;
      s_src_q  <= s_src_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q != StEmpty);
  assign bus.out_data  = m_data_q;
  assign bus.out_src   = m_src_q;
endmodule

// File: doc/stream_muxn.md
# stream_muxn

Parametrised N-to-1 stream multiplexer with valid/ready handshaking, a registered output and a one-entry skid buffer. It is the next generation of the datapath's combinational mux2/mux3/mux4 blocks. It is used wherever several producers share one consumer across a pipeline boundary, such as writeback-source selection or memory-request merging. Selection is either externally driven or round-robin arbitrated.

## Interface
- WIDTH, 32, data width in bits (1..64)
- N, 4, number of input channels (2..16)
- SELW, $clog2(N), select/source index width (derived, not overridden)
- MODE, 0, 0 = select-driven (sel chooses channel); 1 = round-robin among valid inputs (sel ignored)

Ports:
- clk  input  1  clock; all state on rising edge
- reset  input  1  synchronous, active-high reset
- sel  input  SELW  channel select (MODE 0 only)
- in_valid  input  N  per-channel valid
- in_data  input  N*WIDTH  channel i at bits [i*WIDTH +: WIDTH]
- in_ready  output  N  per-channel ready; one-hot or zero
- out_valid  output  1  output word valid
- out_data  output  WIDTH  output word
- out_src  output  SELW  index of channel that produced out_data
- out_ready  input  1  consumer ready

## Operation
- Reset is synchronous and active-high, and dominates all other inputs. On reset: out_valid=0, out_data=0, out_src=0, skid empty, rr_ptr=0. in_ready is 0 during the reset cycle.
- Grant selection in MODE 0:
  - Candidate is sel. If sel>=N, no channel is granted.
  - in_ready[sel] is asserted only when sel<N and the skid is empty.
  - in_ready does not depend on in_valid[sel].
- Grant selection in MODE 1:
  - Winner is the first i with in_valid[i]=1, scanning rr_ptr, rr_ptr+1, … with modulo-N wrap.
  - in_ready[winner] is asserted only when the skid is empty. All in_ready bits are 0 when no input is valid.
  - rr_ptr updates to (winner+1) mod N only on an accepted transfer. It is otherwise held.
- Transfer rules:
  - An input transfer is in_valid[g] && in_ready[g].
  - An output transfer is out_valid && out_ready.
- in_ready must not depend combinationally on out_ready. It is a function of skid state, sel/in_valid and rr_ptr only.
- Buffer FSM (main register M, skid register S):
  - EMPTY (M invalid): an input transfer loads M and goes to ONE.
  - ONE (M valid, S empty):
    - Input transfer and output transfer together: load M, stay ONE.
    - Output transfer only: go to EMPTY.
    - Input transfer only: load S, go to FULL.
    - Neither: hold.
  - FULL (M and S valid): in_ready = 0. An output transfer moves S into M and goes to ONE.
- out_valid = M valid; out_data/out_src = M contents. M is held stable while out_valid && !out_ready.
- Data moves unmodified: no width change, no reordering. Words are delivered in acceptance order.
- Unused select codes (sel>=N, N not a power of two) block transfers. They never emit zero data.

## Timing
- Latency: 1 cycle. A word accepted at edge k appears on out_valid/out_data after edge k.
- Throughput: 1 word/cycle sustained while out_ready=1.
- Back-pressure: when out_ready drops, at most one further word is accepted (into S). in_ready deasserts starting the cycle after S fills.
- Recovery: from FULL with out_ready=1, in_ready reasserts the cycle after S drains into M. Order is preserved (M, then S, then new data).
- Select changes (MODE 0) take effect in the same cycle. Words already in M/S are unaffected.
- Reset mid-operation: contents of M and S are discarded, with no output transfer on the reset cycle. rr_ptr returns to 0.
- No combinational path from out_ready to in_ready. Paths from sel/in_valid to in_ready are permitted.

## Test plan
- Reset: assert reset with in_valid=4'b1111 and out_ready=1. Required: out_valid=0, out_data=0, out_src=0, in_ready=0 during reset; in_ready reasserts the cycle after reset falls.
- MODE 0 streaming: N=4, sel=2, ch2 sends 0xA0..0xA7 back-to-back with out_ready=1. Required: 8 words out in order at 1/cycle, out_src=2, 1-cycle latency; in_ready=4'b0100 throughout.
- Back-pressure/skid: out_ready=0 while ch2 sends 0x11 then 0x22. Required: state reaches FULL and in_ready=0. Then raise out_ready. Required: outputs 0x11, then 0x22, with no loss or duplication.
- Invalid select: N=3, sel=3, in_valid=3'b111. Required: in_ready=0 and out_valid stays 0 for 10 cycles.
- Round-robin fairness: MODE 1, N=4, in_valid=4'b1111 held, out_ready=1. Required: out_src sequence 0,1,2,3,0,…; with in_valid=4'b1010 the sequence is 1,3,1,3.
- Random stress: random in_valid, out_ready and sel with a scoreboard. Required: in-order, lossless delivery; M stable while stalled; in_ready at most one-hot.
